// File: rtl/decode_if.sv
// Handshake and decoded-field bundle for decode_stage.
// Upstream side: flush, in_valid, in_inst, in_ready.
// Downstream side: out_valid, out_ready, opcode, rd, rn, rm, imm, fmt, illegal, illegal_cnt.
// slave modport is the decode stage; master modport is whatever drives and consumes it.
interface decode_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) ();
  logic              flush;
  logic              in_valid;
  logic [25:0]       in_inst;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rn;
  logic [4:0]        rm;
  logic [DATA_W-1:0] imm;
  logic [1:0]        fmt;
  logic              illegal;
  logic [CNT_W-1:0]  illegal_cnt;

  modport slave (
    input  flush, in_valid, in_inst, out_ready,
    output in_ready, out_valid, opcode, rd, rn, rm, imm, fmt, illegal, illegal_cnt
  );

  modport master (
    output flush, in_valid, in_inst, out_ready,
    input  in_ready, out_valid, opcode, rd, rn, rm, imm, fmt, illegal, illegal_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage with a 2-entry skid buffer.
// Ports:
//   clk    - single clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - decode_if.slave: upstream valid/ready + raw 26-bit word, downstream valid/ready
//            + decoded fields (opcode, rd, rn, rm, imm, fmt, illegal) and illegal_cnt
// Instructions are decoded combinationally on the way in and stored already decoded; the
// outputs show the FIFO head and are forced to zero whenever nothing is held.
module decode_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter bit          SIGN_EXT = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  decode_if.slave bus
);

  localparam logic [1:0] FmtR   = 2'd0;
  localparam logic [1:0] FmtI10 = 2'd1;
  localparam logic [1:0] FmtJ20 = 2'd2;
  localparam logic [1:0] FmtIll = 2'd3;

  typedef struct packed {
    logic [5:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [DATA_W-1:0] imm;
    logic [1:0]        fmt;
  } entry_t;

  entry_t            dec;
  logic [DATA_W-1:0] imm10_ext, imm20_ext;

  entry_t           mem_q [2];
  entry_t           mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic   push, pop, out_valid;
  entry_t head;

  // Size casts of signed operands replicate the MSB, so SIGN_EXT just picks the signedness.
  always_comb begin
    if (SIGN_EXT) begin
      imm10_ext = DATA_W'($signed(bus.in_inst[9:0]));
      imm20_ext = DATA_W'($signed(bus.in_inst[19:0]));
    end else begin
      imm10_ext = DATA_W'(bus.in_inst[9:0]);
      imm20_ext = DATA_W'(bus.in_inst[19:0]);
    end
  end

  // Decode on {class, m}; fields unused by a format stay at their zero default.
  always_comb begin
    dec        = '0;
    dec.opcode = bus.in_inst[25:20];
    unique case (bus.in_inst[25:23])
      3'b000, 3'b010: begin
        dec.fmt = FmtR;
        dec.rd  = bus.in_inst[19:15];
        dec.rn  = bus.in_inst[14:10];
        dec.rm  = bus.in_inst[9:5];
      end
      3'b001, 3'b011, 3'b100, 3'b110: begin
        dec.fmt = FmtI10;
        dec.rd  = bus.in_inst[19:15];
        dec.rn  = bus.in_inst[14:10];
        dec.imm = imm10_ext;
      end
      3'b111: begin
        dec.fmt = FmtJ20;
        dec.imm = imm20_ext;
      end
      3'b101: begin
        dec.fmt = FmtIll;
      end
      default: dec.fmt = FmtIll;
    endcase
  end

  assign push      = bus.in_valid & in_ready_q;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (bus.flush) begin
      // Flush wins over push and pop; an instruction accepted this edge is dropped.
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
    in_ready_d = (cnt_d < 2'd2);
  end

  // Illegal count follows acceptance, so it also counts instructions that flush discards.
  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (push && (dec.fmt == FmtIll) && (ill_cnt_q != {CNT_W{1'b1}})) begin
      ill_cnt_d = ill_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b0;
      ill_cnt_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  always_comb begin
    head = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.opcode      = head.opcode;
  assign bus.rd          = head.rd;
  assign bus.rn          = head.rn;
  assign bus.rm          = head.rm;
  assign bus.imm         = head.imm;
  assign bus.fmt         = head.fmt;
  assign bus.illegal     = out_valid & (head.fmt == FmtIll);
  assign bus.illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of single-instruction decodes plus hand-written
// sequences for backpressure, illegal counting/saturation, flush and mid-stream reset.
module tb_decode_stage;

  logic clk;
  logic rst_n;

  decode_if #(.DATA_W(32), .CNT_W(2)) bus ();

  decode_stage #(.DATA_W(32), .SIGN_EXT(1'b1), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [25:0] inst;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [31:0] imm;
    logic [1:0]  fmt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [5:0] op, input logic [4:0] rd,
                            input logic [4:0] rn, input logic [4:0] rm, input logic [31:0] imm,
                            input logic [1:0] fmt);
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, ".opcode"}, 64'(bus.opcode), 64'(op));
    check({tag, ".rd"}, 64'(bus.rd), 64'(rd));
    check({tag, ".rn"}, 64'(bus.rn), 64'(rn));
    check({tag, ".rm"}, 64'(bus.rm), 64'(rm));
    check({tag, ".imm"}, 64'(bus.imm), 64'(imm));
    check({tag, ".fmt"}, 64'(bus.fmt), 64'(fmt));
    check({tag, ".illegal"}, 64'(bus.illegal), 64'(fmt == 2'd3));
  endtask

  function automatic logic [25:0] mk_r(input logic [4:0] rd);
    return {6'h01, rd, 5'd0, 5'd0, 5'd0};
  endfunction

  initial begin
    vecs[0] = '{{6'h01, 5'd3, 5'd4, 5'd5, 5'd0}, 6'h01, 5'd3, 5'd4, 5'd5, 32'h0, 2'd0};
    vecs[1] = '{{6'b001000, 5'd1, 5'd2, 10'h3FF}, 6'h08, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 2'd1};
    vecs[2] = '{{6'b111000, 20'h80000}, 6'h38, 5'd0, 5'd0, 5'd0, 32'hFFF8_0000, 2'd2};
    vecs[3] = '{{6'b100000, 5'd31, 5'd0, 10'h1FF}, 6'h20, 5'd31, 5'd0, 5'd0, 32'h0000_01FF, 2'd1};
    vecs[4] = '{{6'b110101, 5'd7, 5'd9, 10'h200}, 6'h35, 5'd7, 5'd9, 5'd0, 32'hFFFF_FE00, 2'd1};
    vecs[5] = '{{6'b010011, 5'd17, 5'd18, 5'd19, 5'h1F}, 6'h13, 5'd17, 5'd18, 5'd19, 32'h0, 2'd0};
    vecs[6] = '{{6'b111111, 20'h7FFFF}, 6'h3F, 5'd0, 5'd0, 5'd0, 32'h0007_FFFF, 2'd2};

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b0;

    // Held in reset.
    #12;
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.in_ready", 64'(bus.in_ready), 64'd0);
    check("rst.imm", 64'(bus.imm), 64'd0);
    check("rst.illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst.out_valid", 64'(bus.out_valid), 64'd0);

    // Table: one instruction at a time, consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst  = vecs[i].inst;
      @(negedge clk);
      check_head($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm,
                 vecs[i].imm, vecs[i].fmt);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d.drain_valid", i), 64'(bus.out_valid), 64'd0);
      check($sformatf("vec%0d.drain_opcode", i), 64'(bus.opcode), 64'd0);
      check($sformatf("vec%0d.drain_imm", i), 64'(bus.imm), 64'd0);
    end

    // Backpressure: three pushes with the consumer stalled, then drain in order.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = mk_r(5'd10);
    @(negedge clk);
    check("bp.in_ready_after1", 64'(bus.in_ready), 64'd1);
    bus.in_inst = mk_r(5'd11);
    @(negedge clk);
    check("bp.in_ready_after2", 64'(bus.in_ready), 64'd0);
    check("bp.head_a", 64'(bus.rd), 64'd10);
    bus.in_inst = mk_r(5'd12);
    @(negedge clk);
    check("bp.in_ready_held", 64'(bus.in_ready), 64'd0);
    check_head("bp.stable_a", 6'h01, 5'd10, 5'd0, 5'd0, 32'h0, 2'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp.head_b", 64'(bus.rd), 64'd11);
    check("bp.in_ready_reopen", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("bp.head_c", 64'(bus.rd), 64'd12);
    check("bp.valid_c", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp.empty", 64'(bus.out_valid), 64'd0);

    // Illegal instruction accepted four times: counter 1,2,3 then saturates at 3.
    bus.in_valid = 1'b1;
    bus.in_inst  = {6'b101000, 20'h12345};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_head($sformatf("ill%0d", k), 6'h28, 5'd0, 5'd0, 5'd0, 32'h0, 2'd3);
      check($sformatf("ill%0d.cnt", k), 64'(bus.illegal_cnt), 64'((k < 3) ? k + 1 : 3));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("ill.empty", 64'(bus.out_valid), 64'd0);

    // Flush with two entries held and a new instruction offered.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = mk_r(5'd1);
    @(negedge clk);
    bus.in_inst = mk_r(5'd2);
    @(negedge clk);
    check("fl.full", 64'(bus.in_ready), 64'd0);
    bus.in_inst = mk_r(5'd3);
    bus.flush   = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl.out_valid", 64'(bus.out_valid), 64'd0);
    check("fl.in_ready", 64'(bus.in_ready), 64'd1);
    check("fl.opcode", 64'(bus.opcode), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("fl.nothing_appears", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = mk_r(5'd4);
    @(negedge clk);
    bus.in_inst = mk_r(5'd5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst.illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    check("mrst.in_ready", 64'(bus.in_ready), 64'd0);
    check("mrst.rd", 64'(bus.rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst.in_ready_after", 64'(bus.in_ready), 64'd1);
    check("mrst.out_valid_after", 64'(bus.out_valid), 64'd0);

    // Illegal accepted on a flush edge is dropped but still counted.
    bus.in_valid = 1'b1;
    bus.in_inst  = mk_r(5'd20);
    @(negedge clk);
    bus.in_inst = {6'b101000, 20'h0ABCD};
    bus.flush   = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("fd.out_valid", 64'(bus.out_valid), 64'd0);
    check("fd.in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_inst   = mk_r(5'd21);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_head("fd.next", 6'h01, 5'd21, 5'd0, 5'd0, 32'h0, 2'd0);
    check("fd.cnt", 64'(bus.illegal_cnt), 64'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("fd.empty", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
